// File: rtl/key_led_ctrl.sv
// key_led_ctrl: push-button LED mode controller.
// The active-low key is synchronised, debounced and edge-detected into a
// one-cycle press pulse. Each press steps the mode OFF -> ON -> SLOW -> FAST,
// and the LED is driven from a registered pattern generator.
// Optional feature macro: BREATH_EN adds a PWM "breathing" mode (code 4)
// after FAST; without it no PWM logic exists and FAST wraps to OFF.
module key_led_ctrl #(
    parameter int DEBOUNCE_CYC  = 1_000_000,
    parameter int SLOW_HALF_CYC = 25_000_000,
    parameter int FAST_HALF_CYC = 6_250_000,
    parameter int CNT_W         = 25
`ifdef BREATH_EN
    ,
    parameter int BR_TICK       = 500
`endif
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key,
    output logic       led,
    output logic [2:0] mode,
    output logic       key_press
);

    typedef enum logic [2:0] {
        MODE_OFF    = 3'd0,
        MODE_ON     = 3'd1,
        MODE_SLOW   = 3'd2,
`ifdef BREATH_EN
        MODE_FAST   = 3'd3,
        MODE_BREATH = 3'd4
`else
        MODE_FAST   = 3'd3
`endif
    } mode_e;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_HALF_CYC - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_HALF_CYC - 1);

    logic [1:0]       rst_sync_q, rst_sync_d;
    logic             rst_n_int;

    logic [1:0]       sync_q, sync_d;
    logic             key_sync;
    logic             key_stable_q, key_stable_d;
    logic             key_stable_dly_q, key_stable_dly_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             key_press_q, key_press_d;

    mode_e            mode_q, mode_d;
    logic             mode_chg;

    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [CNT_W-1:0] half_last;
    logic             phase_q, phase_d;
    logic             led_q, led_d;

`ifdef BREATH_EN
    localparam logic [CNT_W-1:0] BR_LAST = CNT_W'(BR_TICK - 1);

    logic [CNT_W-1:0] br_tick_q, br_tick_d;
    logic [6:0]       pwm_step_q, pwm_step_d;
    logic [6:0]       duty_q, duty_d;
    logic             dir_up_q, dir_up_d;
`endif

    // Reset release is re-timed to the clock; assertion passes straight through.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    // Reset synchroniser register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n_int = rst_sync_q[1];

    // Two-flop key synchroniser, debounce counter and falling-edge press detect.
    always_comb begin
        sync_d           = {sync_q[0], key};
        key_sync         = sync_q[1];
        deb_cnt_d        = deb_cnt_q;
        key_stable_d     = key_stable_q;
        key_stable_dly_d = key_stable_q;
        key_press_d      = key_stable_dly_q & ~key_stable_q;
        if (key_sync == key_stable_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            key_stable_d = key_sync;
            deb_cnt_d    = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    // Mode sequencer: one step per press, illegal codes fall back to OFF.
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            MODE_OFF:  if (key_press_q) mode_d = MODE_ON;
            MODE_ON:   if (key_press_q) mode_d = MODE_SLOW;
            MODE_SLOW: if (key_press_q) mode_d = MODE_FAST;
`ifdef BREATH_EN
            MODE_FAST:   if (key_press_q) mode_d = MODE_BREATH;
            MODE_BREATH: if (key_press_q) mode_d = MODE_OFF;
`else
            MODE_FAST: if (key_press_q) mode_d = MODE_OFF;
`endif
            default:   mode_d = MODE_OFF;
        endcase
        mode_chg = (mode_d != mode_q);
    end

    // Blink half-period counter; restarts lit on every mode change.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        half_last   = (mode_q == MODE_SLOW) ? SLOW_LAST : FAST_LAST;
        if (mode_chg) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (mode_q == MODE_SLOW || mode_q == MODE_FAST) begin
            if (blink_cnt_q == half_last) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end else begin
            blink_cnt_d = '0;
        end
    end

`ifdef BREATH_EN
    // Breathing PWM: 100 steps per period, duty ramps 0..100..0 one per period.
    always_comb begin
        br_tick_d  = br_tick_q;
        pwm_step_d = pwm_step_q;
        duty_d     = duty_q;
        dir_up_d   = dir_up_q;
        if (mode_chg || mode_q != MODE_BREATH) begin
            br_tick_d  = '0;
            pwm_step_d = '0;
            duty_d     = '0;
            dir_up_d   = 1'b1;
        end else if (br_tick_q != BR_LAST) begin
            br_tick_d = br_tick_q + 1'b1;
        end else begin
            br_tick_d = '0;
            if (pwm_step_q != 7'd99) begin
                pwm_step_d = pwm_step_q + 7'd1;
            end else begin
                pwm_step_d = '0;
                if (dir_up_q) begin
                    duty_d = duty_q + 7'd1;
                    if (duty_q == 7'd99) dir_up_d = 1'b0;
                end else begin
                    duty_d = duty_q - 7'd1;
                    if (duty_q == 7'd1) dir_up_d = 1'b1;
                end
            end
        end
    end

    // Breathing PWM state register.
    always_ff @(posedge sys_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            br_tick_q  <= '0;
            pwm_step_q <= '0;
            duty_q     <= '0;
            dir_up_q   <= 1'b1;
        end else begin
            br_tick_q  <= br_tick_d;
            pwm_step_q <= pwm_step_d;
            duty_q     <= duty_d;
            dir_up_q   <= dir_up_d;
        end
    end
`endif

    // LED pattern selected by the current mode.
    always_comb begin
        led_d = 1'b0;
        case (mode_q)
            MODE_OFF:    led_d = 1'b0;
            MODE_ON:     led_d = 1'b1;
            MODE_SLOW:   led_d = phase_q;
            MODE_FAST:   led_d = phase_q;
`ifdef BREATH_EN
            MODE_BREATH: led_d = (pwm_step_q < duty_q);
`endif
            default:     led_d = 1'b0;
        endcase
    end

    // Main state register for key path, mode, blink and LED.
    always_ff @(posedge sys_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            sync_q           <= 2'b11;
            key_stable_q     <= 1'b1;
            key_stable_dly_q <= 1'b1;
            deb_cnt_q        <= '0;
            key_press_q      <= 1'b0;
            mode_q           <= MODE_OFF;
            blink_cnt_q      <= '0;
            phase_q          <= 1'b1;
            led_q            <= 1'b0;
        end else begin
            sync_q           <= sync_d;
            key_stable_q     <= key_stable_d;
            key_stable_dly_q <= key_stable_dly_d;
            deb_cnt_q        <= deb_cnt_d;
            key_press_q      <= key_press_d;
            mode_q           <= mode_d;
            blink_cnt_q      <= blink_cnt_d;
            phase_q          <= phase_d;
            led_q            <= led_d;
        end
    end

    assign led       = led_q;
    assign mode      = mode_q;
    assign key_press = key_press_q;

endmodule

// File: tb/tb_key_led_ctrl.sv
// Self-checking bench for key_led_ctrl with short simulation timings.
// A behavioural model tracks the key history, the mode and the time spent
// in the current mode, and derives the expected outputs every clock.
module tb_key_led_ctrl;

    localparam int DEB  = 8;
    localparam int SLOW = 20;
    localparam int FAST = 5;
    localparam int BRT  = 2;
`ifdef BREATH_EN
    localparam int NM = 5;
`else
    localparam int NM = 4;
`endif

    logic       sys_clk;
    logic       sys_rst_n;
    logic       key;
    logic       led;
    logic [2:0] mode;
    logic       key_press;

    int vectors;
    int errors;
    int press_total;
    int first_press_at;

    bit raw_hist[$];
    bit m_stable;
    bit m_fell;
    bit m_press;
    bit m_led;
    int m_mode;
    int m_age;

    key_led_ctrl #(
        .DEBOUNCE_CYC (DEB),
        .SLOW_HALF_CYC(SLOW),
        .FAST_HALF_CYC(FAST),
`ifdef BREATH_EN
        .BR_TICK      (BRT),
`endif
        .CNT_W        (25)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .key      (key),
        .led      (led),
        .mode     (mode),
        .key_press(key_press)
    );

    // 100 MHz-style bench clock; only the cycle count matters here.
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Counts one comparison and reports it if observed and expected differ.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Expected LED for a mode that has been active for 'age' clocks.
    function automatic bit ledFor(input int md, input int age);
        int p, d, duty, step;
        case (md)
            0: return 1'b0;
            1: return 1'b1;
            2: return ((age / SLOW) % 2) == 0;
            3: return ((age / FAST) % 2) == 0;
            4: begin
                p    = age / (100 * BRT);
                step = (age % (100 * BRT)) / BRT;
                d    = p % 200;
                duty = (d <= 100) ? d : 200 - d;
                return step < duty;
            end
            default: return 1'b0;
        endcase
    endfunction

    function automatic void modelReset();
        raw_hist.delete();
        m_stable = 1'b1;
        m_fell   = 1'b0;
        m_press  = 1'b0;
        m_led    = 1'b0;
        m_mode   = 0;
        m_age    = 0;
    endfunction

    // Advance the model by one clock edge with key value k present at that edge.
    // The debounced level flips once the synchronised key (two clocks late)
    // has shown the opposite level for DEB consecutive edges.
    function automatic void modelStep(input bit k);
        int n, idx, s, p_mode, p_age;
        bit flip, p_stable, p_fell, p_press;
        n = raw_hist.size();
        raw_hist.push_back(k);
        p_stable = m_stable;
        p_fell   = m_fell;
        p_press  = m_press;
        p_mode   = m_mode;
        p_age    = m_age;
        flip = 1'b1;
        for (int j = 0; j < DEB; j++) begin
            idx = n - j - 2;
            s = (idx >= 0) ? int'(raw_hist[idx]) : 1;
            if (s == int'(p_stable)) flip = 1'b0;
        end
        m_stable = flip ? ~p_stable : p_stable;
        m_fell   = p_stable & ~m_stable;
        m_press  = p_fell;
        m_mode   = p_press ? (p_mode + 1) % NM : p_mode;
        m_age    = (m_mode != p_mode) ? 0 : p_age + 1;
        m_led    = ledFor(p_mode, p_age);
    endfunction

    // Hold key at level k for 'cycles' clocks, checking every output each clock.
    task automatic applyStimulus(input bit k, input int cycles);
        for (int c = 1; c <= cycles; c++) begin
            key = k;
            @(posedge sys_clk);
            modelStep(k);
            #1;
            checkOutput("led", int'(led), int'(m_led));
            checkOutput("mode", int'(mode), m_mode);
            checkOutput("key_press", int'(key_press), int'(m_press));
            if (key_press) begin
                press_total++;
                if (first_press_at < 0) first_press_at = c;
            end
        end
    endtask

    // Asynchronous reset pulse placed between clock edges, outputs checked at once.
    task automatic applyReset();
        key = 1'b1;
        #2 sys_rst_n = 1'b0;
        #1;
        checkOutput("rst_led", int'(led), 0);
        checkOutput("rst_mode", int'(mode), 0);
        checkOutput("rst_key_press", int'(key_press), 0);
        repeat (3) @(posedge sys_clk);
        #3 sys_rst_n = 1'b1;
        modelReset();
    endtask

    task automatic cleanPress(input int low_cyc, input int high_cyc);
        applyStimulus(1'b0, low_cyc);
        applyStimulus(1'b1, high_cyc);
    endtask

    initial begin
        int r, len, toggles;
        bit lvl;
        vectors        = 0;
        errors         = 0;
        press_total    = 0;
        first_press_at = -1;
        sys_rst_n      = 1'b1;
        key            = 1'b1;
        modelReset();
        #1;

        // Idle after reset: nothing lit, no presses.
        applyReset();
        press_total = 0;
        applyStimulus(1'b1, 100);
        checkOutput("idle_presses", press_total, 0);

        // Single clean press held 50 clocks, pulse 11 clocks after the edge.
        press_total    = 0;
        first_press_at = -1;
        applyStimulus(1'b0, 50);
        checkOutput("press_latency", first_press_at, 11);
        checkOutput("press_count", press_total, 1);
        checkOutput("mode_after_press", int'(mode), 1);
        checkOutput("led_after_press", int'(led), 1);
        press_total = 0;
        applyStimulus(1'b1, 50);
        checkOutput("release_presses", press_total, 0);

        // Bouncy press: four 3-low/3-high pulses then stable low.
        press_total = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 3);
            applyStimulus(1'b1, 3);
        end
        applyStimulus(1'b0, 40);
        applyStimulus(1'b1, 40);
        checkOutput("bounce_presses", press_total, 1);
        checkOutput("bounce_mode", int'(mode), 2);

        // From reset: three presses walk ON, SLOW, FAST with blink checked each clock.
        applyReset();
        applyStimulus(1'b1, 20);
        for (int i = 1; i <= 3; i++) begin
            cleanPress(20, 60);
            checkOutput("mode_seq", int'(mode), i);
        end
        cleanPress(20, 20);
        checkOutput("wrap_mode", int'(mode), NM == 4 ? 0 : 4);

        // Reset in the middle of SLOW blinking.
        applyReset();
        applyStimulus(1'b1, 20);
        cleanPress(20, 20);
        cleanPress(20, 30);
        checkOutput("pre_reset_mode", int'(mode), 2);
        applyReset();
        press_total = 0;
        applyStimulus(1'b1, 50);
        checkOutput("post_reset_presses", press_total, 0);

        // Randomised key activity: clean presses, short glitches, bursts, idle gaps.
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 3);
            case (r)
                0: cleanPress($urandom_range(DEB + 3, 30), $urandom_range(DEB + 3, 40));
                1: begin
                    applyStimulus(1'b0, $urandom_range(1, DEB - 1));
                    applyStimulus(1'b1, $urandom_range(DEB + 3, 30));
                end
                2: begin
                    toggles = $urandom_range(4, 8);
                    lvl = 1'b0;
                    for (int t = 0; t < toggles; t++) begin
                        applyStimulus(lvl, $urandom_range(1, 4));
                        lvl = ~lvl;
                    end
                    applyStimulus(($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0, 20);
                    applyStimulus(1'b1, 20);
                end
                default: begin
                    len = $urandom_range(1, 60);
                    applyStimulus(1'b1, len);
                end
            endcase
        end

`ifdef BREATH_EN
        // Breathing mode: four presses reach it, then the duty ramp runs past its peak.
        applyReset();
        applyStimulus(1'b1, 20);
        for (int i = 0; i < 4; i++) cleanPress(20, 20);
        checkOutput("breath_mode", int'(mode), 4);
        applyStimulus(1'b1, 200 * 105);
        cleanPress(20, 20);
        checkOutput("breath_exit_mode", int'(mode), 0);
        checkOutput("breath_exit_led", int'(led), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
